// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie-break, bus lock and a
// stalled-strobe watchdog that terminates hung cycles with an error.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,

  output logic [1:0]  gnt_o,
  output logic [7:0]  tmo_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TMO  = 2'd2;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  gnt;
  logic        pri;
  logic [15:0] stall_cnt;
  logic [7:0]  tmo_cnt;

  logic        g_cyc;
  logic        g_stb;
  logic        g_we;
  logic        g_lock;
  logic [31:0] g_addr;
  logic [31:0] g_dat;
  logic [3:0]  g_sel;

  logic        busy;
  logic        tmo_cycle;
  logic        owned;
  logic        term;
  logic        release_bus;
  logic        stalled;
  logic        expire;

  // Signals of whichever master currently holds the grant.
  always_comb begin
    if (gnt[1]) begin
      g_cyc  = m1_cyc_i;
      g_stb  = m1_stb_i;
      g_we   = m1_we_i;
      g_lock = m1_lock_i;
      g_addr = m1_addr_i;
      g_dat  = m1_dat_i;
      g_sel  = m1_sel_i;
    end else begin
      g_cyc  = m0_cyc_i;
      g_stb  = m0_stb_i;
      g_we   = m0_we_i;
      g_lock = m0_lock_i;
      g_addr = m0_addr_i;
      g_dat  = m0_dat_i;
      g_sel  = m0_sel_i;
    end
  end

  always_comb begin
    busy        = (state == ST_BUSY);
    tmo_cycle   = (state == ST_TMO);
    owned       = busy | tmo_cycle;
    term        = s_ack_i | s_err_i | s_rty_i;
    release_bus = busy & ~g_cyc & ~g_lock;
    stalled     = busy & g_cyc & g_stb & ~term;
    expire      = stalled & (stall_cnt == TMO_LAST);
  end

  // A slave termination in the last stalled cycle clears stalled, so it
  // always beats the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      gnt       <= 2'b00;
      pri       <= 1'b0;
      stall_cnt <= 16'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          stall_cnt <= 16'd0;
          if (m0_cyc_i && m1_cyc_i) begin
            gnt   <= pri ? 2'b10 : 2'b01;
            state <= ST_BUSY;
          end else if (m0_cyc_i) begin
            gnt   <= 2'b01;
            state <= ST_BUSY;
          end else if (m1_cyc_i) begin
            gnt   <= 2'b10;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_bus) begin
            state     <= ST_IDLE;
            gnt       <= 2'b00;
            pri       <= gnt[0];
            stall_cnt <= 16'd0;
          end else if (expire) begin
            state     <= ST_TMO;
            stall_cnt <= 16'd0;
            if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end else if (stalled) begin
            stall_cnt <= stall_cnt + 16'd1;
          end else begin
            stall_cnt <= 16'd0;
          end
        end
        ST_TMO: begin
          state     <= ST_IDLE;
          gnt       <= 2'b00;
          pri       <= gnt[0];
          stall_cnt <= 16'd0;
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= 2'b00;
          stall_cnt <= 16'd0;
        end
      endcase
    end
  end

  // The watchdog cycle keeps address/data steady but withdraws cyc/stb.
  always_comb begin
    s_cyc_o  = busy & g_cyc;
    s_stb_o  = busy & g_stb;
    s_we_o   = owned & g_we;
    s_addr_o = owned ? g_addr : 32'd0;
    s_dat_o  = owned ? g_dat  : 32'd0;
    s_sel_o  = owned ? g_sel  : 4'd0;
  end

  always_comb begin
    m0_dat_o = gnt[0] ? s_dat_i : 32'd0;
    m0_ack_o = busy & gnt[0] & s_ack_i;
    m0_rty_o = busy & gnt[0] & s_rty_i;
    m0_err_o = gnt[0] & ((busy & s_err_i) | tmo_cycle);
    m1_dat_o = gnt[1] ? s_dat_i : 32'd0;
    m1_ack_o = busy & gnt[1] & s_ack_i;
    m1_rty_o = busy & gnt[1] & s_rty_i;
    m1_err_o = gnt[1] & ((busy & s_err_i) | tmo_cycle);
  end

  assign gnt_o     = gnt;
  assign tmo_cnt_o = tmo_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT=16: single master, contention,
// lock, watchdog timeout, termination-wins boundary and mid-cycle reset.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic [31:0] m0_addr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic [31:0] m1_addr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;
  logic [7:0]  tmo_cnt_o;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
    .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .tmo_cnt_o(tmo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic waitCycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic lock,
                               input logic [31:0] addr, input logic [31:0] dat,
                               input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_lock_i = lock;
      m0_addr_i = addr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_lock_i = lock;
      m1_addr_i = addr; m1_dat_i = dat; m1_sel_i = sel;
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
      $error("[TB] %s observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    s_dat_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle();
    waitCycle();
    checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
    checkOutput("rst_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("rst_addr", s_addr_o, 32'd0);
    checkOutput("rst_tmo", 32'(tmo_cnt_o), 32'd0);
    rst_i = 1'b0;

    // Single master write, slave acks on the second granted cycle.
    applyStimulus(0, 1, 1, 1, 0, 32'h8, 32'h80, 4'b0001);
    checkOutput("single_idle_gnt", 32'(gnt_o), 32'd0);
    checkOutput("single_idle_cyc", 32'(s_cyc_o), 32'd0);
    waitCycle(); #1;
    checkOutput("single_gnt", 32'(gnt_o), 32'h1);
    checkOutput("single_cyc", 32'(s_cyc_o), 32'd1);
    checkOutput("single_we", 32'(s_we_o), 32'd1);
    checkOutput("single_addr", s_addr_o, 32'h8);
    checkOutput("single_dat", s_dat_o, 32'h80);
    checkOutput("single_sel", 32'(s_sel_o), 32'h1);
    checkOutput("single_noack", 32'(m0_ack_o), 32'd0);
    waitCycle();
    s_ack_i = 1'b1; s_dat_i = 32'h1234; #1;
    checkOutput("single_ack", 32'(m0_ack_o), 32'd1);
    checkOutput("single_m1_noack", 32'(m1_ack_o), 32'd0);
    checkOutput("single_m0_dat", m0_dat_o, 32'h1234);
    checkOutput("single_m1_dat", m1_dat_o, 32'd0);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    checkOutput("single_hold_gnt", 32'(gnt_o), 32'h1);
    checkOutput("single_drop_cyc", 32'(s_cyc_o), 32'd0);
    waitCycle(); #1;
    checkOutput("single_release", 32'(gnt_o), 32'd0);

    // Contention straight after reset: m0 wins, m1 follows after an idle cycle.
    rst_i = 1'b1;
    waitCycle();
    rst_i = 1'b0;
    applyStimulus(0, 1, 1, 0, 0, 32'h100, 32'd0, 4'hF);
    applyStimulus(1, 1, 1, 0, 0, 32'h200, 32'd0, 4'hF);
    waitCycle(); #1;
    checkOutput("tie_gnt_m0", 32'(gnt_o), 32'h1);
    checkOutput("tie_addr_m0", s_addr_o, 32'h100);
    s_ack_i = 1'b1; #1;
    checkOutput("tie_ack_m0", 32'(m0_ack_o), 32'd1);
    checkOutput("tie_noack_m1", 32'(m1_ack_o), 32'd0);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle(); #1;
    checkOutput("tie_idle_gap", 32'(gnt_o), 32'd0);
    checkOutput("tie_idle_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("tie_idle_addr", s_addr_o, 32'd0);
    waitCycle(); #1;
    checkOutput("tie_gnt_m1", 32'(gnt_o), 32'h2);
    checkOutput("tie_addr_m1", s_addr_o, 32'h200);
    s_ack_i = 1'b1; #1;
    checkOutput("tie_ack_m1", 32'(m1_ack_o), 32'd1);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(0, 1, 1, 0, 0, 32'h100, 32'd0, 4'hF);
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle();
    applyStimulus(1, 1, 1, 0, 0, 32'h200, 32'd0, 4'hF);
    waitCycle(); #1;
    checkOutput("tie2_gnt_m0", 32'(gnt_o), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle();

    // Lock: m1 keeps the bus over a three-cycle cyc gap while m0 waits.
    applyStimulus(1, 1, 1, 0, 1, 32'h204, 32'd0, 4'hF);
    waitCycle(); #1;
    checkOutput("lock_gnt", 32'(gnt_o), 32'h2);
    s_ack_i = 1'b1; #1;
    checkOutput("lock_ack", 32'(m1_ack_o), 32'd1);
    waitCycle();
    s_ack_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 32'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 1, 1, 0, 32'h104, 32'h55, 4'hF);
    checkOutput("lock_gap1_gnt", 32'(gnt_o), 32'h2);
    checkOutput("lock_gap1_stb", 32'(s_stb_o), 32'd0);
    waitCycle(); #1;
    checkOutput("lock_gap2_gnt", 32'(gnt_o), 32'h2);
    checkOutput("lock_gap2_stb", 32'(s_stb_o), 32'd0);
    waitCycle();
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    checkOutput("lock_gap3_gnt", 32'(gnt_o), 32'h2);
    checkOutput("lock_gap3_m0_ack", 32'(m0_ack_o), 32'd0);
    waitCycle(); #1;
    checkOutput("lock_release", 32'(gnt_o), 32'd0);
    waitCycle(); #1;
    checkOutput("lock_gnt_m0", 32'(gnt_o), 32'h1);
    checkOutput("lock_addr_m0", s_addr_o, 32'h104);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle();

    // Timeout: 16 stalled cycles, error on the following cycle.
    applyStimulus(0, 1, 1, 0, 0, 32'h40, 32'd0, 4'hF);
    waitCycle(); #1;
    checkOutput("tmo_gnt", 32'(gnt_o), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      checkOutput($sformatf("tmo_stall%0d_err", k), 32'(m0_err_o), 32'd0);
      if (k == 16) checkOutput("tmo_stall16_stb", 32'(s_stb_o), 32'd1);
      waitCycle(); #1;
    end
    checkOutput("tmo_err", 32'(m0_err_o), 32'd1);
    checkOutput("tmo_m1_err", 32'(m1_err_o), 32'd0);
    checkOutput("tmo_stb_forced", 32'(s_stb_o), 32'd0);
    checkOutput("tmo_cyc_forced", 32'(s_cyc_o), 32'd0);
    checkOutput("tmo_cnt_err_cycle", 32'(tmo_cnt_o), 32'd1);
    waitCycle(); #1;
    checkOutput("tmo_idle_gnt", 32'(gnt_o), 32'd0);
    checkOutput("tmo_idle_err", 32'(m0_err_o), 32'd0);
    checkOutput("tmo_cnt", 32'(tmo_cnt_o), 32'd1);

    // Boundary: ack on the 16th stalled cycle wins over the watchdog.
    waitCycle(); #1;
    checkOutput("bnd_gnt", 32'(gnt_o), 32'h1);
    for (int k = 1; k <= 15; k++) waitCycle();
    s_ack_i = 1'b1; #1;
    checkOutput("bnd_ack", 32'(m0_ack_o), 32'd1);
    checkOutput("bnd_err_same", 32'(m0_err_o), 32'd0);
    waitCycle();
    s_ack_i = 1'b0; #1;
    checkOutput("bnd_err_next", 32'(m0_err_o), 32'd0);
    checkOutput("bnd_gnt_kept", 32'(gnt_o), 32'h1);
    checkOutput("bnd_stb_kept", 32'(s_stb_o), 32'd1);
    checkOutput("bnd_tmo_cnt", 32'(tmo_cnt_o), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle();

    // Reset in the middle of a stalled m1 write.
    applyStimulus(1, 1, 1, 1, 0, 32'h300, 32'hCAFE, 4'hF);
    waitCycle(); #1;
    checkOutput("rstw_gnt", 32'(gnt_o), 32'h2);
    checkOutput("rstw_we", 32'(s_we_o), 32'd1);
    waitCycle();
    waitCycle();
    rst_i = 1'b1; #1;
    waitCycle(); #1;
    checkOutput("rstw_gnt_drop", 32'(gnt_o), 32'd0);
    checkOutput("rstw_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("rstw_tmo_cnt", 32'(tmo_cnt_o), 32'd0);
    checkOutput("rstw_m1_err", 32'(m1_err_o), 32'd0);
    checkOutput("rstw_m0_err", 32'(m0_err_o), 32'd0);
    rst_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    waitCycle(); #1;
    checkOutput("rstw_after_gnt", 32'(gnt_o), 32'd0);
    checkOutput("rstw_after_err", 32'(m1_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
